// File: rtl/dbp_pkg.sv
// Shared types for the dynamic branch predictor: 2-bit direction counter and its update rule.
package dbp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_t;

    localparam bp_cnt_t RESET_CNT = WNT;

    // Saturating step toward the resolved direction; never wraps past ST or SNT.
    function automatic bp_cnt_t sat_update(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t nxt;
        case (cnt)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dbp_btb.sv
// Tagged branch target buffer: one combinational read port, one synchronous write port.
module dbp_btb #(
    parameter int PC_W       = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  rd_hit_o,
    output logic [PC_W-1:0]       rd_target_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [PC_W-1:0]       wr_target_i
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]     target_q [ENTRIES];

    // NOTE: the array is built from flops, not RAM, so every entry can be cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i]  <= 1'b1;
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    // Reads see the stored value only; a same-cycle write becomes visible next cycle.
    always_comb begin
        rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
        rd_target_o = rd_hit_o ? target_q[rd_idx_i] : '0;
    end

endmodule

// File: rtl/dbp_param_predictor.sv
// Fetch-stage dynamic branch predictor: tagged BTB, 2-bit PHT, optional gshare history,
// and saturating resolution / misprediction counters.
module dbp_param_predictor
    import dbp_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 6,
    parameter int GHR_BITS   = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [PC_W-1:0]  PC_curr,
    input  logic [PC_W-1:0]  IF_ID_PC_curr,
    input  logic             was_branch,
    input  logic             actual_taken,
    input  logic [PC_W-1:0]  actual_target,
    input  logic             branch_mispredicted,
    output logic             predicted_taken,
    output logic [PC_W-1:0]  predicted_target,
    output logic             btb_hit,
    output logic [CNT_W-1:0] pred_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;

    logic [INDEX_BITS-1:0] f_idx, t_idx, f_pidx, t_pidx;
    logic [TAG_BITS-1:0]   f_tag, t_tag;
    logic [GHR_W-1:0]      hist_q, hist_d;
    logic [GHR_W-1:0]      ghr_q, ghr_d;
    logic [CNT_W-1:0]      pred_cnt_q, pred_cnt_d;
    logic [CNT_W-1:0]      mis_cnt_q, mis_cnt_d;
    logic [1:0]            f_cnt;
    logic                  train;
    logic                  unused_pc;
    bp_cnt_t               pht_q [ENTRIES];

    assign f_idx  = PC_curr[INDEX_BITS:1];
    assign f_tag  = PC_curr[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    assign t_idx  = IF_ID_PC_curr[INDEX_BITS:1];
    assign t_tag  = IF_ID_PC_curr[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    assign train  = enable & was_branch;

    // In bimodal mode hist_q never leaves zero, so both XORs collapse to the plain PC index.
    assign f_pidx = f_idx ^ INDEX_BITS'(hist_q);
    assign t_pidx = t_idx ^ INDEX_BITS'(ghr_q);

    // Bit 0 and the bits above the tag do not take part in lookup.
    assign unused_pc = ^{PC_curr, IF_ID_PC_curr};

    dbp_btb #(
        .PC_W       (PC_W),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (f_idx),
        .rd_tag_i    (f_tag),
        .rd_hit_o    (btb_hit),
        .rd_target_o (predicted_target),
        .wr_en_i     (train & actual_taken),
        .wr_idx_i    (t_idx),
        .wr_tag_i    (t_tag),
        .wr_target_i (actual_target)
    );

    assign f_cnt           = pht_q[f_pidx];
    assign predicted_taken = btb_hit & f_cnt[1];
    assign pred_count      = pred_cnt_q;
    assign mispred_count   = mis_cnt_q;

    // NOTE: every variable gets a hold default before any condition, so no path infers a latch.
    always_comb begin
        ghr_d      = ghr_q;
        hist_d     = hist_q;
        pred_cnt_d = pred_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        if (enable) begin
            ghr_d = hist_q;
        end
        if (train) begin
            if (GHR_BITS > 0) begin
                hist_d = GHR_W'({hist_q, actual_taken});
            end
            if (pred_cnt_q != '1) begin
                pred_cnt_d = pred_cnt_q + CNT_W'(1);
            end
            if (branch_mispredicted && (mis_cnt_q != '1)) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state updates use <= so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q      <= '0;
            hist_q     <= '0;
            pred_cnt_q <= '0;
            mis_cnt_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= RESET_CNT;
            end
        end else begin
            ghr_q      <= ghr_d;
            hist_q     <= hist_d;
            pred_cnt_q <= pred_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            if (train) begin
                pht_q[t_pidx] <= sat_update(pht_q[t_pidx], actual_taken);
            end
        end
    end

endmodule

// File: tb/tb_dbp_param_predictor.sv
// Bench for dbp_param_predictor: a bimodal and a gshare instance share stimulus and are
// compared against a cycle-level reference model through an expectation queue.
module tb_dbp_param_predictor;

    logic        clk                 = 1'b0;
    logic        rst_n               = 1'b0;
    logic        enable              = 1'b0;
    logic [15:0] PC_curr             = '0;
    logic [15:0] IF_ID_PC_curr       = '0;
    logic        was_branch          = 1'b0;
    logic        actual_taken        = 1'b0;
    logic [15:0] actual_target       = '0;
    logic        branch_mispredicted = 1'b0;

    logic        b_taken, b_hit, g_taken, g_hit;
    logic [15:0] b_tgt, g_tgt;
    logic [2:0]  b_pc, b_mp;
    logic [15:0] g_pc, g_mp;

    always #5 clk = ~clk;

    dbp_param_predictor #(
        .PC_W(16), .INDEX_BITS(4), .TAG_BITS(6), .GHR_BITS(0), .CNT_W(3)
    ) u_bi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .PC_curr(PC_curr),
        .IF_ID_PC_curr(IF_ID_PC_curr), .was_branch(was_branch), .actual_taken(actual_taken),
        .actual_target(actual_target), .branch_mispredicted(branch_mispredicted),
        .predicted_taken(b_taken), .predicted_target(b_tgt), .btb_hit(b_hit),
        .pred_count(b_pc), .mispred_count(b_mp)
    );

    dbp_param_predictor #(
        .PC_W(16), .INDEX_BITS(4), .TAG_BITS(6), .GHR_BITS(2), .CNT_W(16)
    ) u_gs (
        .clk(clk), .rst_n(rst_n), .enable(enable), .PC_curr(PC_curr),
        .IF_ID_PC_curr(IF_ID_PC_curr), .was_branch(was_branch), .actual_taken(actual_taken),
        .actual_target(actual_target), .branch_mispredicted(branch_mispredicted),
        .predicted_taken(g_taken), .predicted_target(g_tgt), .btb_hit(g_hit),
        .pred_count(g_pc), .mispred_count(g_mp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model, index 0 = bimodal with 3-bit counters, 1 = gshare (2 history bits).
    int m_pht [2][16];
    bit m_v   [2][16];
    int m_tag [2][16];
    int m_tg  [2][16];
    int m_hist [2];
    int m_cap  [2];
    int m_pcnt [2];
    int m_mcnt [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_pht[k][i] = 1;
                m_v[k][i]   = 1'b0;
                m_tag[k][i] = 0;
                m_tg[k][i]  = 0;
            end
            m_hist[k] = 0;
            m_cap[k]  = 0;
            m_pcnt[k] = 0;
            m_mcnt[k] = 0;
        end
    endfunction

    function automatic void model_predict(input int k, input int pc,
                                          output bit hit, output bit tk, output int tgt);
        int idx, pidx;
        idx  = (pc >> 1) & 15;
        pidx = idx ^ m_hist[k];
        hit  = m_v[k][idx] && (m_tag[k][idx] == ((pc >> 5) & 63));
        tk   = hit && (m_pht[k][pidx] >= 2);
        tgt  = hit ? m_tg[k][idx] : 0;
    endfunction

    function automatic void model_edge(input int k);
        int idx, pidx, nh, mask, cmax;
        if (!enable) return;
        mask = (k == 1) ? 3 : 0;
        cmax = (k == 1) ? 65535 : 7;
        nh   = m_hist[k];
        if (was_branch) begin
            idx  = (int'(IF_ID_PC_curr) >> 1) & 15;
            pidx = idx ^ m_cap[k];
            if (actual_taken) begin
                if (m_pht[k][pidx] < 3) m_pht[k][pidx]++;
                m_v[k][idx]   = 1'b1;
                m_tag[k][idx] = (int'(IF_ID_PC_curr) >> 5) & 63;
                m_tg[k][idx]  = int'(actual_target);
            end else if (m_pht[k][pidx] > 0) begin
                m_pht[k][pidx]--;
            end
            if (m_pcnt[k] < cmax) m_pcnt[k]++;
            if (branch_mispredicted && (m_mcnt[k] < cmax)) m_mcnt[k]++;
            nh = ((m_hist[k] << 1) | int'(actual_taken)) & mask;
        end
        m_cap[k]  = m_hist[k];
        m_hist[k] = nh;
    endfunction

    typedef struct {
        string tag;
        int    k;
        bit    hit;
        bit    tk;
        int    tgt;
        int    pcnt;
        int    mcnt;
    } exp_t;

    exp_t sb_q[$];
    int   o_hit [2];
    int   o_tk  [2];
    int   o_tgt [2];
    int   o_pc  [2];
    int   o_mp  [2];

    task automatic sb_compare(input exp_t e);
        string s;
        s = (e.k == 0) ? {e.tag, "_bi"} : {e.tag, "_gs"};
        check({s, "_hit"},   32'(o_hit[e.k]), 32'(e.hit));
        check({s, "_taken"}, 32'(o_tk[e.k]),  32'(e.tk));
        check({s, "_tgt"},   32'(o_tgt[e.k]), 32'(e.tgt));
        check({s, "_pcnt"},  32'(o_pc[e.k]),  32'(e.pcnt));
        check({s, "_mcnt"},  32'(o_mp[e.k]),  32'(e.mcnt));
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance the model at the next posedge.
    task automatic cycle(input logic [15:0] pc, input logic en, input logic wb,
                         input logic [15:0] ifpc, input logic tk, input logic [15:0] tgt,
                         input logic mp, input string tag);
        exp_t e;
        PC_curr             = pc;
        enable              = en;
        was_branch          = wb;
        IF_ID_PC_curr       = ifpc;
        actual_taken        = tk;
        actual_target       = tgt;
        branch_mispredicted = mp;
        for (int k = 0; k < 2; k++) begin
            e.tag = tag;
            e.k   = k;
            model_predict(k, int'(pc), e.hit, e.tk, e.tgt);
            e.pcnt = m_pcnt[k];
            e.mcnt = m_mcnt[k];
            sb_q.push_back(e);
        end
        @(negedge clk);
        o_hit[0] = int'(b_hit);  o_tk[0] = int'(b_taken);  o_tgt[0] = int'(b_tgt);
        o_pc[0]  = int'(b_pc);   o_mp[0] = int'(b_mp);
        o_hit[1] = int'(g_hit);  o_tk[1] = int'(g_taken);  o_tgt[1] = int'(g_tgt);
        o_pc[1]  = int'(g_pc);   o_mp[1] = int'(g_mp);
        while (sb_q.size() > 0) sb_compare(sb_q.pop_front());
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bi_taken"}, 32'(b_taken), 32'h0);
        check({tag, "_bi_tgt"},   32'(b_tgt),   32'h0);
        check({tag, "_bi_hit"},   32'(b_hit),   32'h0);
        check({tag, "_bi_pcnt"},  32'(b_pc),    32'h0);
        check({tag, "_bi_mcnt"},  32'(b_mp),    32'h0);
        check({tag, "_gs_taken"}, 32'(g_taken), 32'h0);
        check({tag, "_gs_hit"},   32'(g_hit),   32'h0);
        check({tag, "_gs_pcnt"},  32'(g_pc),    32'h0);
    endtask

    bit pred_hist [17];
    int mp_mid;

    initial begin
        model_reset();
        PC_curr = 16'h0008;
        #2;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Learn: first resolution is invisible to the same-cycle fetch, then WNT->WT predicts taken.
        cycle(16'h0008, 1, 1, 16'h0008, 1, 16'h0080, 0, "learn_t1");
        cycle(16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 0, "learn_f1");
        check("learn_hit",   32'(o_hit[0]), 32'h1);
        check("learn_taken", 32'(o_tk[0]),  32'h1);
        check("learn_tgt",   32'(o_tgt[0]), 32'h0080);
        cycle(16'h0008, 1, 1, 16'h0008, 1, 16'h0080, 0, "learn_t2");

        // Saturation: ST absorbs extra taken outcomes, so one not-taken still predicts taken.
        for (int i = 0; i < 5; i++) cycle(16'h0008, 1, 1, 16'h0008, 1, 16'h0080, 0, "sat_t");
        cycle(16'h0008, 1, 1, 16'h0008, 0, 16'h0000, 0, "sat_n1");
        cycle(16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 0, "sat_f1");
        check("sat_n1_taken", 32'(o_tk[0]), 32'h1);
        cycle(16'h0008, 1, 1, 16'h0008, 0, 16'h0000, 0, "sat_n2");
        cycle(16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 0, "sat_f2");
        check("sat_n2_taken", 32'(o_tk[0]),  32'h0);
        check("sat_n2_hit",   32'(o_hit[0]), 32'h1);

        // Alias: 0x0028 shares index 4 with 0x0008 but carries a different tag.
        cycle(16'h0008, 1, 1, 16'h0008, 1, 16'h0080, 0, "alias_t8");
        cycle(16'h0028, 1, 0, 16'h0000, 0, 16'h0000, 0, "alias_f28");
        check("alias_f28_hit",   32'(o_hit[0]), 32'h0);
        check("alias_f28_taken", 32'(o_tk[0]),  32'h0);
        cycle(16'h0028, 1, 1, 16'h0028, 1, 16'h0100, 0, "alias_t28");
        cycle(16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 0, "alias_f8");
        check("alias_f8_hit", 32'(o_hit[0]), 32'h0);

        // Stall, then a mispredict flag without a branch: neither may change any state.
        cycle(16'h0008, 0, 1, 16'h0008, 1, 16'h0200, 1, "stall");
        cycle(16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 1, "stall_f8");
        check("stall_f8_hit", 32'(o_hit[0]), 32'h0);
        cycle(16'h0028, 1, 0, 16'h0000, 0, 16'h0000, 0, "stall_f28");
        check("stall_f28_hit", 32'(o_hit[0]), 32'h1);
        check("stall_f28_tgt", 32'(o_tgt[0]), 32'h0100);
        check("bi_pcnt_sat",   32'(o_pc[0]),  32'h7);
        check("gs_pcnt_11",    32'(o_pc[1]),  32'd11);
        check("gs_mcnt_0",     32'(o_mp[1]),  32'h0);

        // Async reset mid-cycle while a resolution is pending.
        cycle(16'h0008, 1, 1, 16'h0008, 1, 16'h0080, 0, "pre_rst_t");
        PC_curr       = 16'h0008;
        IF_ID_PC_curr = 16'h0008;
        was_branch    = 1'b1;
        actual_taken  = 1'b1;
        enable        = 1'b1;
        @(negedge clk);
        check("pre_rst_hit", 32'(b_hit), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        enable     = 1'b0;
        was_branch = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Gshare: alternating outcomes at 0x0008; branch i-1 resolves while branch i is fetched.
        for (int i = 0; i <= 16; i++) begin
            bit ph, pt, tk, mp;
            int ptg;
            model_predict(1, 16'h0008, ph, pt, ptg);
            pred_hist[i] = pt;
            tk = ((i - 1) % 2 == 0);
            mp = (i > 0) && (pred_hist[(i > 0) ? i - 1 : 0] != tk);
            cycle(16'h0008, 1, (i > 0), 16'h0008, tk, 16'h0080, mp, "gs_alt");
            if (i == 9) mp_mid = o_mp[1];
        end
        cycle(16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 0, "gs_end");
        check("gs_pcnt_16",    32'(o_pc[1]),          32'd16);
        check("gs_mcnt_final", 32'(o_mp[1]),          32'd2);
        check("gs_mcnt_flat",  32'(o_mp[1] - mp_mid), 32'd0);
        check("gs_bi_pcnt",    32'(o_pc[0]),          32'h7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
